// File: rtl/gauss_kernel_sequencer.sv
// Sequences InitKernel builds and double-buffers the kernel for convolution.
// Define SIGMA_CACHE_EN to skip rebuilding a kernel whose sigma is already active.
module gauss_kernel_sequencer #(
    parameter int SIZE        = 5,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    input  logic [2:0]               cfg_sigma,
    output logic                     cfg_ready,
    output logic                     init_start,
    output logic [2:0]               init_sigma,
    input  logic                     init_done,
    input  logic [SIZE*SIZE*8-1:0]   init_kernel,
    input  logic [63:0]              init_sum,
    input  logic                     conv_busy,
    output logic [SIZE*SIZE*8-1:0]   kernel,
    output logic [63:0]              kernel_sum,
    output logic [2:0]               kernel_sigma,
    output logic                     kernel_valid,
    output logic                     swap_pulse,
    output logic                     err_timeout,
    input  logic                     err_clr
);
    localparam int KW = SIZE * SIZE * 8;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, PEND_SWAP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       sigma_q;
    logic [2:0]       shadow_sigma;
    logic [KW-1:0]    shadow_kernel;
    logic [63:0]      shadow_sum;
    logic             accept;
    logic             hit;
    logic             capture;
    logic             timeout;
    logic             swap;

    assign accept     = (state == IDLE) && cfg_valid;
    assign init_sigma = sigma_q;

`ifdef SIGMA_CACHE_EN
    assign hit = kernel_valid && (cfg_sigma == kernel_sigma);
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cfg_ready  = 1'b0;
        init_start = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        swap       = 1'b0;
        unique case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid && !hit) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                init_start = 1'b1;
                state_nxt  = WAIT_DONE;
            end
            WAIT_DONE: begin
                // done on the terminal-count cycle still counts as success
                if (init_done) begin
                    capture   = 1'b1;
                    state_nxt = PEND_SWAP;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PEND_SWAP: begin
                if (!conv_busy) begin
                    swap      = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            sigma_q       <= '0;
            shadow_sigma  <= '0;
            shadow_kernel <= '0;
            shadow_sum    <= '0;
            kernel        <= '0;
            kernel_sum    <= '0;
            kernel_sigma  <= '0;
            kernel_valid  <= 1'b0;
            swap_pulse    <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            swap_pulse <= swap || (accept && hit);
            if (accept) sigma_q <= cfg_sigma;
            if (state == LAUNCH)         cnt <= '0;
            else if (state == WAIT_DONE) cnt <= cnt + CNT_W'(1);
            if (capture) begin
                shadow_kernel <= init_kernel;
                shadow_sum    <= init_sum;
                shadow_sigma  <= sigma_q;
            end
            if (swap) begin
                kernel       <= shadow_kernel;
                kernel_sum   <= shadow_sum;
                kernel_sigma <= shadow_sigma;
                kernel_valid <= 1'b1;
            end
            // a timeout outranks a same-cycle clear
            if (timeout)                  err_timeout <= 1'b1;
            else if (err_clr || accept)   err_timeout <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gauss_kernel_sequencer.sv
// Directed bench for gauss_kernel_sequencer with a delay-programmable builder model.
// Cycle n counts negedges after the request's acceptance cycle (n=0).
`timescale 1ns/1ps
module tb_gauss_kernel_sequencer;
    localparam int SIZE = 5;
    localparam int KW   = SIZE * SIZE * 8;
    localparam logic [KW-1:0] KA = {25{8'h21}};
    localparam logic [KW-1:0] KB = {25{8'h3C}};
    localparam logic [KW-1:0] KC = {25{8'hA5}};
    localparam logic [KW-1:0] KD = {25{8'h77}};
    localparam logic [KW-1:0] KE = {25{8'h0F}};
    localparam logic [63:0] SA = 64'd825;
    localparam logic [63:0] SB = 64'd1500;
    localparam logic [63:0] SC = 64'd4125;
    localparam logic [63:0] SD = 64'd2975;
    localparam logic [63:0] SE = 64'd375;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic [2:0]    cfg_sigma = 3'd0;
    logic          cfg_ready;
    logic          init_start;
    logic [2:0]    init_sigma;
    logic          init_done;
    logic [KW-1:0] init_kernel = '0;
    logic [63:0]   init_sum = '0;
    logic          conv_busy = 1'b0;
    logic [KW-1:0] kernel;
    logic [63:0]   kernel_sum;
    logic [2:0]    kernel_sigma;
    logic          kernel_valid;
    logic          swap_pulse;
    logic          err_timeout;
    logic          err_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_delay = 0;
    int bcnt = 0;
    logic armed = 1'b0;

    always #5 clk = ~clk;

    // builder model: done for one cycle done_delay cycles after start (0 = never)
    assign init_done = armed && (done_delay != 0) && (bcnt == done_delay);

    always @(posedge clk) begin
        if (init_start) begin
            armed <= 1'b1;
            bcnt  <= 1;
        end else if (armed) begin
            if (init_done) armed <= 1'b0;
            else           bcnt  <= bcnt + 1;
        end
    end

    gauss_kernel_sequencer dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_sigma(cfg_sigma), .cfg_ready(cfg_ready),
        .init_start(init_start), .init_sigma(init_sigma),
        .init_done(init_done), .init_kernel(init_kernel), .init_sum(init_sum),
        .conv_busy(conv_busy),
        .kernel(kernel), .kernel_sum(kernel_sum), .kernel_sigma(kernel_sigma),
        .kernel_valid(kernel_valid), .swap_pulse(swap_pulse),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (kernel !== '0 || kernel_sum !== 64'd0 || kernel_sigma !== 3'd0) begin
            errors++;
            $display("FAIL reset_bank got sum=%0d sigma=%0d want 0", kernel_sum, kernel_sigma);
        end
        checks++;
        if ({kernel_valid, swap_pulse, err_timeout, init_start} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got v=%b sw=%b err=%b st=%b want 0",
                     kernel_valid, swap_pulse, err_timeout, init_start);
        end
        checks++;
        if (init_sigma !== 3'd0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cfg got isig=%0d rdy=%b want 0/1", init_sigma, cfg_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_build();
        int starts = 0;
        int swap_at = -1;
        done_delay  = 25;
        init_kernel = KA;
        init_sum    = SA;
        conv_busy   = 1'b0;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL build_ready got %b want 1", cfg_ready);
        end
        cfg_valid = 1'b1;
        cfg_sigma = 3'd2;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (init_start) starts++;
            if (swap_pulse && swap_at < 0) swap_at = n;
            if (n == 1) begin
                cfg_valid = 1'b0;
                checks++;
                if (init_start !== 1'b1 || init_sigma !== 3'd2) begin
                    errors++;
                    $display("FAIL build_launch got st=%b isig=%0d want 1/2", init_start, init_sigma);
                end
            end
            if (n == 27) begin
                checks++;
                if (kernel_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL build_prevalid got %b want 0", kernel_valid);
                end
            end
        end
        checks++;
        if (starts != 1) begin
            errors++;
            $display("FAIL build_starts got %0d want 1", starts);
        end
        checks++;
        if (swap_at != 28) begin
            errors++;
            $display("FAIL build_latency got %0d want 28", swap_at);
        end
        checks++;
        if (kernel !== KA || kernel_sum !== SA || kernel_sigma !== 3'd2 || kernel_valid !== 1'b1) begin
            errors++;
            $display("FAIL build_bank got sum=%0d sigma=%0d v=%b want 825/2/1",
                     kernel_sum, kernel_sigma, kernel_valid);
        end
    endtask

    task automatic test_timeout();
        int swaps = 0;
        done_delay  = 0;
        init_kernel = KB;
        init_sum    = SB;
        cfg_valid   = 1'b1;
        cfg_sigma   = 3'd4;
        for (int n = 1; n <= 72; n++) begin
            @(negedge clk);
            if (swap_pulse) swaps++;
            if (n == 65) begin
                checks++;
                if (err_timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL tmo_early got %b want 0", err_timeout);
                end
            end
            if (n == 66) begin
                checks++;
                if (err_timeout !== 1'b1 || cfg_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL tmo_set_wins got err=%b rdy=%b want 1/1", err_timeout, cfg_ready);
                end
            end
            if (n == 72) begin
                checks++;
                if (err_timeout !== 1'b1) begin
                    errors++;
                    $display("FAIL tmo_sticky got %b want 1", err_timeout);
                end
            end
            if (n == 1)  cfg_valid = 1'b0;
            if (n == 60) err_clr = 1'b1;
            if (n == 66) err_clr = 1'b0;
        end
        checks++;
        if (swaps != 0 || kernel !== KA || kernel_sigma !== 3'd2 || kernel_valid !== 1'b1) begin
            errors++;
            $display("FAIL tmo_retain got swaps=%0d sigma=%0d v=%b want 0/2/1",
                     swaps, kernel_sigma, kernel_valid);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clear got %b want 0", err_timeout);
        end
    endtask

    task automatic test_terminal();
        int swap_at = -1;
        done_delay  = 64;
        init_kernel = KC;
        init_sum    = SC;
        cfg_valid   = 1'b1;
        cfg_sigma   = 3'd5;
        for (int n = 1; n <= 72; n++) begin
            @(negedge clk);
            if (swap_pulse && swap_at < 0) swap_at = n;
            if (n == 1) cfg_valid = 1'b0;
        end
        checks++;
        if (swap_at != 67 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL term_swap got at=%0d err=%b want 67/0", swap_at, err_timeout);
        end
        checks++;
        if (kernel !== KC || kernel_sum !== SC || kernel_sigma !== 3'd5) begin
            errors++;
            $display("FAIL term_bank got sum=%0d sigma=%0d want 4125/5", kernel_sum, kernel_sigma);
        end
    endtask

    task automatic test_busy();
        int swap_at = -1;
        done_delay  = 25;
        init_kernel = KB;
        init_sum    = SB;
        conv_busy   = 1'b1;
        cfg_valid   = 1'b1;
        cfg_sigma   = 3'd3;
        for (int n = 1; n <= 75; n++) begin
            @(negedge clk);
            if (swap_pulse && swap_at < 0) swap_at = n;
            if (n == 27 || n == 67) begin
                checks++;
                if (cfg_ready !== 1'b0 || kernel !== KC || kernel_sigma !== 3'd5) begin
                    errors++;
                    $display("FAIL busy_hold n=%0d got rdy=%b sigma=%0d want 0/5",
                             n, cfg_ready, kernel_sigma);
                end
            end
            if (n == 1)  cfg_valid = 1'b0;
            if (n == 67) conv_busy = 1'b0;
        end
        checks++;
        if (swap_at != 68) begin
            errors++;
            $display("FAIL busy_swap got %0d want 68", swap_at);
        end
        checks++;
        if (kernel !== KB || kernel_sum !== SB || kernel_sigma !== 3'd3) begin
            errors++;
            $display("FAIL busy_bank got sum=%0d sigma=%0d want 1500/3", kernel_sum, kernel_sigma);
        end
    endtask

    task automatic test_reset_mid();
        int swaps = 0;
        int starts = 0;
        done_delay  = 25;
        init_kernel = KD;
        init_sum    = SD;
        cfg_valid   = 1'b1;
        cfg_sigma   = 3'd6;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n >= 12 && swap_pulse) swaps++;
            if (n >= 12 && init_start) starts++;
            if (n == 1) cfg_valid = 1'b0;
            if (n == 11) begin
                rst = 1'b1;
                #1;
                checks++;
                if (kernel !== '0 || kernel_sum !== 64'd0 || kernel_sigma !== 3'd0 ||
                    kernel_valid !== 1'b0 || init_sigma !== 3'd0 ||
                    swap_pulse !== 1'b0 || init_start !== 1'b0 || err_timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL rstmid_async got v=%b sigma=%0d isig=%0d want 0",
                             kernel_valid, kernel_sigma, init_sigma);
                end
            end
            if (n == 12) rst = 1'b0;
        end
        checks++;
        if (swaps != 0 || starts != 0 || kernel_valid !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_late got swaps=%0d starts=%0d v=%b rdy=%b want 0/0/0/1",
                     swaps, starts, kernel_valid, cfg_ready);
        end
    endtask

    task automatic test_back_to_back();
        int starts = 0;
        int nswap = 0;
        int sw1 = -1;
        int sw2 = -1;
        int acc2 = -1;
        int exp_starts;
        int exp_sw2;
`ifdef SIGMA_CACHE_EN
        exp_starts = 1;
        exp_sw2    = 7;
`else
        exp_starts = 2;
        exp_sw2    = 12;
`endif
        done_delay  = 3;
        init_kernel = KE;
        init_sum    = SE;
        conv_busy   = 1'b0;
        cfg_valid   = 1'b1;
        cfg_sigma   = 3'd1;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (init_start) starts++;
            if (swap_pulse) begin
                nswap++;
                if (sw1 < 0)      sw1 = n;
                else if (sw2 < 0) sw2 = n;
            end
            if (acc2 >= 0 && n == acc2 + 1) cfg_valid = 1'b0;
            if (acc2 < 0 && cfg_valid && cfg_ready) acc2 = n;
        end
        checks++;
        if (acc2 != 6) begin
            errors++;
            $display("FAIL b2b_accept got %0d want 6", acc2);
        end
        checks++;
        if (starts != exp_starts) begin
            errors++;
            $display("FAIL b2b_starts got %0d want %0d", starts, exp_starts);
        end
        checks++;
        if (sw1 != 6 || sw2 != exp_sw2 || nswap != 2) begin
            errors++;
            $display("FAIL b2b_swaps got %0d,%0d n=%0d want 6,%0d n=2", sw1, sw2, nswap, exp_sw2);
        end
        checks++;
        if (kernel !== KE || kernel_sum !== SE || kernel_sigma !== 3'd1 || kernel_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_bank got sum=%0d sigma=%0d v=%b want 375/1/1",
                     kernel_sum, kernel_sigma, kernel_valid);
        end
    endtask

    initial begin
        test_reset();
        test_build();
        test_timeout();
        test_terminal();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gauss_kernel_sequencer.md
Name: gauss_kernel_sequencer

Overview:
Control block that sequences the Gaussian kernel builder (InitKernel) on behalf of the convolution stage. It accepts a sigma configuration request and pulses the builder's start. It captures the finished kernel and sum into a shadow bank, then swaps the shadow bank into the active bank only while the convolution datapath is idle. This gives the convolution engine a glitch-free, double-buffered kernel.

Parameters:
SIZE, 5, kernel edge length; must match the InitKernel instance
TIMEOUT_CYC, 64, maximum cycles to wait for init_done before flagging an error
CNT_W, $clog2(TIMEOUT_CYC+1), wait-counter width (derived; do not override)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cfg_valid  input  1  sigma update request
cfg_sigma  input  3  requested sigma
cfg_ready  output  1  sequencer can accept a request
init_start  output  1  one-cycle start pulse to InitKernel
init_sigma  output  3  sigma driven to InitKernel
init_done  input  1  InitKernel finished
init_kernel  input  SIZE*SIZE*8  kernel from InitKernel; valid when init_done=1
init_sum  input  64  coefficient sum from InitKernel; valid when init_done=1
conv_busy  input  1  convolution mid-frame; swap forbidden while high
kernel  output  SIZE*SIZE*8  active kernel to convolution
kernel_sum  output  64  active sum to convolution
kernel_sigma  output  3  sigma of the active kernel
kernel_valid  output  1  active bank holds a built kernel
swap_pulse  output  1  one cycle, high on the cycle the active bank updates
err_timeout  output  1  sticky timeout flag
err_clr  input  1  clears err_timeout

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE.
  - All outputs 0: kernel, kernel_sum, kernel_sigma, kernel_valid, swap_pulse, err_timeout, init_start, init_sigma.
  - Shadow bank and wait counter cleared.
  - Reset mid-build aborts the build; a later init_done is ignored, because state is IDLE.
- FSM states: IDLE, LAUNCH, WAIT_DONE, PEND_SWAP.
- IDLE:
  - cfg_ready=1.
  - cfg_valid&&cfg_ready latches cfg_sigma into the sigma register, clears err_timeout, and moves to LAUNCH.
  - init_done in IDLE is ignored.
- LAUNCH:
  - init_start=1 for exactly this one cycle; wait counter reset to 0; moves to WAIT_DONE.
- WAIT_DONE:
  - Counter increments each cycle.
  - init_done=1: capture init_kernel and init_sum into the shadow bank, plus the sigma register into shadow sigma; move to PEND_SWAP.
  - Else, counter==TIMEOUT_CYC-1: set err_timeout; return to IDLE; shadow and active banks untouched.
  - init_done on the terminal-count cycle wins; no error is raised.
- PEND_SWAP:
  - conv_busy=0: on this clock edge, copy the shadow bank to kernel, kernel_sum and kernel_sigma; set kernel_valid=1; assert swap_pulse for the following cycle; return to IDLE.
  - conv_busy=1: hold state indefinitely.
- init_sigma is driven from the sigma register continuously; it is stable from LAUNCH through WAIT_DONE.
- cfg_ready=0 in every state except IDLE. Requests are never dropped; they are back-pressured.
- Latency from accepted request to swap_pulse, with conv_busy=0: 1 (LAUNCH) + N (builder cycles until init_done) + 1 (PEND_SWAP) + 1.
- err_clr: clears err_timeout in any state. If err_clr and a timeout occur in the same cycle, set wins.
- Once valid, kernel_valid stays 1 until reset; a timeout does not invalidate the old kernel.
- The active bank changes only on a swap cycle.

Optional Feature:
SIGMA_CACHE_EN.
- Defined: in IDLE, a request with kernel_valid=1 and cfg_sigma==kernel_sigma is accepted but skips the build. The FSM stays in IDLE, and swap_pulse pulses for one cycle on the next cycle. No init_start is issued.
- Undefined: every accepted request triggers a full rebuild.

Test Plan:
1. Reset, then cfg_sigma=2 with a builder model that raises done 25 cycles after start, conv_busy=0 → exactly one init_start, init_sigma=2, swap_pulse 28 cycles after acceptance, kernel/kernel_sum equal the model values, kernel_valid=1.
2. conv_busy=1 held for 40 cycles after init_done → state stays PEND_SWAP, kernel unchanged, cfg_ready=0; swap_pulse occurs the cycle after conv_busy falls.
3. Builder never asserts done, TIMEOUT_CYC=64 → err_timeout=1 after 64 WAIT_DONE cycles, previous kernel (sigma=2) retained; then err_clr=1 → err_timeout=0.
4. init_done coincident with the terminal-count cycle → no error, normal swap.
5. Assert rst for 1 cycle at cycle 10 of a build → all outputs 0 immediately; a late init_done is ignored, and no swap_pulse follows.
6. SIGMA_CACHE_EN defined: request sigma=2 twice → second request produces no init_start and a swap_pulse on the cycle after acceptance. Undefined: the second request rebuilds.
